// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic in one cycle, shift-add multiply over WIDTH cycles.
// Latency: result valid 1 cycle after accept (non-MUL), WIDTH+1 cycles (MUL).
// Backpressure: holds result in DONE until out_ready; in_ready only while IDLE.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flagc,
    output logic                 flagz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt, acc_step;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2*WIDTH-1:0]   result_nxt;
    logic                 flagc_nxt, flagz_nxt;

    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_c;
    logic [WIDTH:0]       ext_sum, ext_diff;
    logic [WIDTH-1:0]     lgc;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle datapath; the MUL entry is unused because MUL goes through MUL_RUN.
    always_comb begin
        ext_sum  = {1'b0, operand1} + {1'b0, operand2};
        ext_diff = {1'b0, operand1} - {1'b0, operand2};
        lgc      = '0;
        alu_c    = 1'b0;
        case (opcode)
            OP_ADD:  alu_c = ext_sum[WIDTH];
            OP_SUB:  alu_c = ext_diff[WIDTH];
            OP_MUL:  lgc   = '0;
            OP_AND:  lgc   = operand1 & operand2;
            OP_OR:   lgc   = operand1 | operand2;
            OP_NAND: lgc   = ~(operand1 & operand2);
            OP_NOR:  lgc   = ~(operand1 | operand2);
            OP_XOR:  lgc   = operand1 ^ operand2;
        endcase
        if (opcode == OP_ADD)
            alu_res = {{(WIDTH-1){1'b0}}, ext_sum};
        else if (opcode == OP_SUB)
            alu_res = {{WIDTH{1'b0}}, ext_diff[WIDTH-1:0]};
        else
            alu_res = {{WIDTH{1'b0}}, lgc};
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        acc_nxt    = acc;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        result_nxt = result;
        flagc_nxt  = flagc;
        flagz_nxt  = flagz;
        acc_step   = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_MUL) begin
                        state_nxt  = MUL_RUN;
                        acc_nxt    = '0;
                        mcand_nxt  = {{WIDTH{1'b0}}, operand1};
                        mplier_nxt = operand2;
                        cnt_nxt    = '0;
                    end else begin
                        state_nxt  = DONE;
                        result_nxt = alu_res;
                        flagc_nxt  = alu_c;
                        flagz_nxt  = (alu_res == '0);
                    end
                end
            end
            MUL_RUN: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                // Outputs stay frozen until the final partial product lands.
                if (cnt == CW'(WIDTH-1)) begin
                    state_nxt  = DONE;
                    result_nxt = acc_step;
                    flagc_nxt  = 1'b0;
                    flagz_nxt  = (acc_step == '0);
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            flagc  <= 1'b0;
            flagz  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            acc    <= acc_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            flagc  <= flagc_nxt;
            flagz  <= flagz_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [31:0] operand1, operand2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flagc, flagz;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flagc(flagc), .flagz(flagz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check outputs, then consume the result.
    task automatic do_op(input string tag, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] er, input logic ec,
                         input logic ez, input int elat);
        int  n;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; opcode = opc; operand1 = a; operand2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; opcode = opc ^ 3'b101; operand1 = ~a; operand2 = ~b;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            if (in_ready) busy_ok = 1'b0;
        end
        chk({tag, ".lat"}, 64'(n), 64'(elat));
        chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
        chk({tag, ".res"}, result, er);
        chk({tag, ".c"}, 64'(flagc), 64'(ec));
        chk({tag, ".z"}, 64'(flagz), 64'(ez));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".drain"}, {62'd0, out_valid, in_ready}, 64'd1);
        chk({tag, ".hold"}, result, er);
    endtask

    initial begin
        bit stable;
        bit never;
        rst_n = 1'b0; in_valid = 1'b0; opcode = 3'b000;
        operand1 = '0; operand2 = '0; out_ready = 1'b0;
        #13;
        chk("rst.res", result, 64'd0);
        chk("rst.flags", {62'd0, flagc, flagz}, 64'd0);
        chk("rst.hs", {62'd0, out_valid, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_ovf", 3'b000, 32'hFFFF_FFFF, 32'h1, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1);
        do_op("sub_brw", 3'b001, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0, 1);
        do_op("sub_eq",  3'b001, 32'd7, 32'd7, 64'd0, 1'b0, 1'b1, 1);
        do_op("mul_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 33);
        do_op("mul_zero", 3'b010, 32'd0, 32'd5, 64'd0, 1'b0, 1'b1, 33);
        do_op("mul_pow", 3'b010, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 33);
        do_op("mul_sm",  3'b010, 32'd6, 32'd7, 64'd42, 1'b0, 1'b0, 33);
        do_op("nand",    3'b101, 32'hFFFF_0000, 32'hFF00_FF00, 64'h0000_0000_00FF_FFFF, 1'b0, 1'b0, 1);
        do_op("nor",     3'b110, 32'hFFFF_FFFF, 32'h0, 64'd0, 1'b0, 1'b1, 1);
        do_op("and",     3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0, 1'b0, 1'b0, 1);
        do_op("or",      3'b100, 32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F, 1'b0, 1'b0, 1);
        do_op("xor",     3'b111, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 64'h0000_0000_5555_5555, 1'b0, 1'b0, 1);

        // Stall in DONE with a new request pending.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b000; operand1 = 32'd1; operand2 = 32'd1;
        @(posedge clk);
        #1;
        opcode = 3'b111; operand1 = 32'h0000_00FF; operand2 = 32'h0000_0F0F;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (result !== 64'd2 || !out_valid || in_ready) stable = 1'b0;
        end
        chk("stall.stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall.rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall.new_vld", 64'(out_valid), 64'd1);
        chk("stall.new_res", result, 64'h0000_0000_0000_0FF0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Abort a multiply mid-run.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b010; operand1 = 32'd9; operand2 = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.res", result, 64'd0);
        chk("abort.flags", {62'd0, flagc, flagz}, 64'd0);
        chk("abort.hs", {62'd0, out_valid, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        never = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) never = 1'b0;
        end
        chk("abort.silent", 64'(never), 64'd1);
        do_op("add_post", 3'b000, 32'd2, 32'd3, 64'd5, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the opcode/operand1/operand2 set is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 The block SHALL have port opcode, input, 3 bits: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 NAND, 110 NOR, 111 XOR.
REQ-007 The block SHALL have ports operand1 and operand2, input, WIDTH bits each: unsigned operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result, flagc and flagz are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: the registered result.
REQ-011 The block SHALL have port flagc, output, 1 bit: carry for ADD, borrow for SUB, 0 otherwise.
REQ-012 The block SHALL have port flagz, output, 1 bit: set when all 2*WIDTH bits of result are zero.

Function
REQ-013 The block SHALL use a state machine with states IDLE, MUL_RUN and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-014 An operation SHALL be accepted when in_valid and in_ready are both 1; opcode and operands are captured at that edge, and later input changes SHALL have no effect.
REQ-015 In IDLE, when in_valid is 0, the block SHALL remain in IDLE with all outputs holding their values.
REQ-016 A non-MUL opcode accepted in IDLE SHALL compute in that cycle, with the state going to DONE on the next edge: out_valid rises 1 cycle after acceptance.
REQ-017 A MUL accepted in IDLE SHALL move to MUL_RUN and perform unsigned shift-add multiplication with one operand2 bit per cycle for exactly WIDTH cycles, then go to DONE: out_valid rises WIDTH+1 cycles after acceptance.
REQ-018 In MUL_RUN, in_ready SHALL be 0 and the cycle counter SHALL count 0 to WIDTH-1; result, flagc and flagz SHALL hold their previous values until DONE is entered.
REQ-019 In DONE, result, flagc and flagz SHALL stay stable while out_ready is 0; when out_valid and out_ready are both 1, the state SHALL return to IDLE, with in_ready high on the next cycle and outputs holding their values.
REQ-020 ADD: result[WIDTH:0] = operand1 + operand2; upper bits 0; flagc = result[WIDTH].
REQ-021 SUB: result[WIDTH-1:0] = (operand1 - operand2) mod 2^WIDTH; upper bits 0; flagc = 1 if and only if operand1 < operand2.
REQ-022 MUL: result = the full 2*WIDTH-bit unsigned product; flagc = 0.
REQ-023 AND/OR/NAND/NOR/XOR: the bitwise op on WIDTH bits, with inversion confined to the low WIDTH bits; upper WIDTH bits 0; flagc = 0.
REQ-024 flagz SHALL be evaluated on the final result only, and be updated together with result when DONE is entered.
REQ-025 Every opcode value SHALL be decoded; the block SHALL have no undefined-opcode behaviour.

Reset
REQ-026 While rst_n = 0, the block SHALL be in state IDLE, with result = 0, flagc = 0, flagz = 0, out_valid = 0 and in_ready = 1.
REQ-027 Asserting rst_n in MUL_RUN or DONE SHALL abort the operation immediately; the pending result is discarded and never presented.
REQ-028 After rst_n deasserts, the first operation SHALL be accepted on the first edge on which in_valid = 1.

Verification (WIDTH = 32)
REQ-029 ADD 0xFFFFFFFF + 0x00000001 -> 1 cycle after acceptance: result = 0x0000000100000000, flagc = 1, flagz = 0, out_valid = 1.
REQ-030 SUB 5 - 7 -> result = 0x00000000FFFFFFFE, flagc = 1; SUB 7 - 7 -> result = 0, flagc = 0, flagz = 1.
REQ-031 MUL 0xFFFFFFFF * 0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, result = 0xFFFFFFFE00000001, in_ready = 0 throughout; MUL 0 * 5 -> flagz = 1.
REQ-032 NAND 0xFFFF0000, 0xFF00FF00 -> result = 0x0000000000FFFFFF, flagc = 0; NOR 0xFFFFFFFF, 0 -> result = 0, flagz = 1.
REQ-033 Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new operands -> result stays stable and nothing is accepted; out_ready = 1 -> in_ready is 1 on the following cycle and the new operation is accepted.
REQ-034 Pulse rst_n low in MUL cycle 10 -> all outputs go to their reset values at once and out_valid never rises for the aborted MUL; a subsequent ADD 2 + 3 -> result = 5.
